// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one step per cycle.
// Signed/unsigned operands, valid/ready on input and output, abort.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic               signed_i,
    input  logic               abort_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               neg_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH+1:0]   a_q;
    logic [WIDTH:0]     qx_q;
    logic [WIDTH:0]     mx_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_out_q;

    logic               accept;
    logic               last;
    logic [WIDTH+1:0]   mx_ext;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+3:0] shf;

    assign accept = (state_q == IDLE) && in_valid_i && !abort_i;
    assign last   = (cnt_q == CW'(WIDTH));
    assign mx_ext = {mx_q[WIDTH], mx_q};

    always_comb begin
        sum = a_q;
        unique case ({qx_q[0], qm1_q})
            2'b01:   sum = a_q + mx_ext;
            2'b10:   sum = a_q - mx_ext;
            default: sum = a_q;
        endcase
    end

    // {A, Qx, q_m1} after the arithmetic right shift; q_m1 old value drops off
    assign shf = {sum[WIDTH+1], sum, qx_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                if (abort_i)   state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: if (abort_i || out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q       <= '0;
            qx_q      <= '0;
            mx_q      <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            prod_q    <= '0;
            neg_out_q <= 1'b0;
        end else if (accept) begin
            a_q   <= '0;
            qx_q  <= {signed_i & multiplier_i[WIDTH-1], multiplier_i};
            mx_q  <= {signed_i & multiplicand_i[WIDTH-1], multiplicand_i};
            qm1_q <= 1'b0;
            cnt_q <= '0;
            neg_q <= signed_i
                     && (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1])
                     && (|multiplicand_i) && (|multiplier_i);
        end else if (state_q == CALC && !abort_i) begin
            a_q   <= shf[2*WIDTH+3:WIDTH+2];
            qx_q  <= shf[WIDTH+1:1];
            qm1_q <= shf[0];
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                prod_q    <= shf[2*WIDTH:1];
                neg_out_q <= neg_q;
            end
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == CALC);
    assign product_o   = prod_q;
    assign neg_o       = neg_out_q;

endmodule
